// File: rtl/column_select_rx.sv
// Receive-side model of the column-select serial chain (595-style shift + storage registers),
// oversampled on clk, with protocol monitoring of frame length and column one-hotness.
module column_select_rx #(
  parameter int unsigned COLUMN_NUMBER = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ser,
  input  logic                     ser_clk,
  input  logic                     stcp,
  input  logic                     enable,
  output logic [COLUMN_NUMBER-1:0] columns,
  output logic                     extra_bit_out,
  output logic                     latch_pulse,
  output logic                     count_err,
  output logic                     multi_sel_err,
  output logic [CNT_W-1:0]         latch_cnt
);

  localparam int unsigned CHAIN = COLUMN_NUMBER + 1;
  localparam int unsigned BCW   = $clog2(2 * CHAIN + 1);
  localparam int unsigned PW    = $clog2(COLUMN_NUMBER + 1) + 1;

  localparam logic [BCW-1:0] BitMax  = BCW'(2 * CHAIN);
  localparam logic [BCW-1:0] BitExp  = BCW'(CHAIN);
  localparam logic [PW-1:0]  PopOne  = PW'(1);

  // Synchronizer lanes: [0] ser, [1] ser_clk, [2] stcp, [3] enable.
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [3:0]             sync_d [SYNC_STAGES];
  logic [1:0]             prev_q, prev_d;
  logic [CHAIN-1:0]       shift_q, shift_d;
  logic [CHAIN-1:0]       storage_q, storage_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                   latch_pulse_q, latch_pulse_d;
  logic                   count_err_q, count_err_d;
  logic                   multi_sel_err_q, multi_sel_err_d;
  logic [CNT_W-1:0]       latch_cnt_q, latch_cnt_d;

  logic                   ser_sync, sclk_sync, stcp_sync, enable_sync;
  logic                   sclk_rise, stcp_rise;
  logic [PW-1:0]          pop_cnt;

  assign ser_sync    = sync_q[SYNC_STAGES-1][0];
  assign sclk_sync   = sync_q[SYNC_STAGES-1][1];
  assign stcp_sync   = sync_q[SYNC_STAGES-1][2];
  assign enable_sync = sync_q[SYNC_STAGES-1][3];

  assign sclk_rise = sclk_sync & ~prev_q[0];
  assign stcp_rise = stcp_sync & ~prev_q[1];

  always_comb begin
    sync_d[0] = {enable, stcp, ser_clk, ser};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = {stcp_sync, sclk_sync};
  end

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < COLUMN_NUMBER; i++) begin
      pop_cnt = pop_cnt + {{(PW-1){1'b0}}, shift_q[i]};
    end
  end

  always_comb begin
    shift_d         = shift_q;
    storage_d       = storage_q;
    bit_cnt_d       = bit_cnt_q;
    latch_pulse_d   = 1'b0;
    count_err_d     = count_err_q;
    multi_sel_err_d = multi_sel_err_q;
    latch_cnt_d     = latch_cnt_q;

    if (sclk_rise) begin
      shift_d = {shift_q[CHAIN-2:0], ser_sync};
      if (bit_cnt_q != BitMax) begin
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end
    end

    // Latch samples the pre-shift word; a coincident shift opens the next frame.
    if (stcp_rise) begin
      storage_d       = shift_q;
      latch_pulse_d   = 1'b1;
      latch_cnt_d     = latch_cnt_q + CNT_W'(1);
      count_err_d     = (bit_cnt_q != BitExp);
      multi_sel_err_d = (pop_cnt > PopOne);
      bit_cnt_d       = sclk_rise ? BCW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q          <= '0;
      shift_q         <= '0;
      storage_q       <= '0;
      bit_cnt_q       <= '0;
      latch_pulse_q   <= 1'b0;
      count_err_q     <= 1'b0;
      multi_sel_err_q <= 1'b0;
      latch_cnt_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q          <= prev_d;
      shift_q         <= shift_d;
      storage_q       <= storage_d;
      bit_cnt_q       <= bit_cnt_d;
      latch_pulse_q   <= latch_pulse_d;
      count_err_q     <= count_err_d;
      multi_sel_err_q <= multi_sel_err_d;
      latch_cnt_q     <= latch_cnt_d;
    end
  end

  assign columns       = storage_q[COLUMN_NUMBER-1:0] & {COLUMN_NUMBER{enable_sync}};
  assign extra_bit_out = storage_q[CHAIN-1];
  assign latch_pulse   = latch_pulse_q;
  assign count_err     = count_err_q;
  assign multi_sel_err = multi_sel_err_q;
  assign latch_cnt     = latch_cnt_q;

endmodule

// File: tb/tb_column_select_rx.sv
// Bench for column_select_rx: directed protocol cases plus random frames against a
// frame-level reference model (bit list per frame, latched word, counters).
module tb_column_select_rx;

  localparam int COLS  = 3;
  localparam int CHAIN = COLS + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ser = 1'b0;
  logic            ser_clk = 1'b0;
  logic            stcp = 1'b0;
  logic            enable = 1'b0;
  logic [COLS-1:0] columns;
  logic            extra_bit_out;
  logic            latch_pulse;
  logic            count_err;
  logic            multi_sel_err;
  logic [15:0]     latch_cnt;

  column_select_rx #(
    .COLUMN_NUMBER(COLS),
    .SYNC_STAGES  (2),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ser          (ser),
    .ser_clk      (ser_clk),
    .stcp         (stcp),
    .enable       (enable),
    .columns      (columns),
    .extra_bit_out(extra_bit_out),
    .latch_pulse  (latch_pulse),
    .count_err    (count_err),
    .multi_sel_err(multi_sel_err),
    .latch_cnt    (latch_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bits of the current frame in send order, latched word, counters.
  bit          frame_q[$];
  logic [3:0]  chain_m;
  logic [3:0]  store_m;
  logic        cerr_m, merr_m, en_m;
  logic [15:0] lcnt_m;
  int          total_lat = 0;
  int          pulse_cnt = 0;
  int          wide_cnt = 0;
  logic        pulse_prev = 1'b0;

  always @(negedge clk) begin
    if (latch_pulse) pulse_cnt++;
    if (latch_pulse && pulse_prev) wide_cnt++;
    pulse_prev = latch_pulse;
  end

  function automatic void model_reset();
    frame_q.delete();
    chain_m = '0;
    store_m = '0;
    cerr_m  = 1'b0;
    merr_m  = 1'b0;
    lcnt_m  = '0;
  endfunction

  function automatic void model_shift(input bit b);
    frame_q.push_back(b);
    chain_m = {chain_m[2:0], b};
  endfunction

  function automatic void model_latch();
    logic [2:0] cw;
    store_m = chain_m;
    cw      = chain_m[2:0];
    cerr_m  = (frame_q.size() != CHAIN);
    merr_m  = ($countones(cw) > 1);
    lcnt_m  = lcnt_m + 16'd1;
    frame_q.delete();
    total_lat++;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit b);
    wait_clk(1);
    ser = b;
    wait_clk(4);
    ser_clk = 1'b1;
    wait_clk(4);
    ser_clk = 1'b0;
    wait_clk(3);
    model_shift(b);
  endtask

  // Sends v[n-1] first, so the first bit sent ends in the extra-bit position.
  task automatic send_frame(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic do_latch();
    wait_clk(1);
    stcp = 1'b1;
    wait_clk(4);
    stcp = 1'b0;
    wait_clk(5);
    model_latch();
  endtask

  task automatic do_both(input bit b);
    wait_clk(1);
    ser = b;
    wait_clk(4);
    ser_clk = 1'b1;
    stcp    = 1'b1;
    wait_clk(4);
    ser_clk = 1'b0;
    stcp    = 1'b0;
    wait_clk(5);
    model_latch();
    model_shift(b);
  endtask

  task automatic set_enable(input bit v);
    wait_clk(1);
    enable = v;
    en_m   = v;
    wait_clk(4);
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check_eq({tag, ".columns"}, 32'(columns), 32'(store_m[2:0] & {3{en_m}}));
    check_eq({tag, ".extra"}, 32'(extra_bit_out), 32'(store_m[3]));
    check_eq({tag, ".count_err"}, 32'(count_err), 32'(cerr_m));
    check_eq({tag, ".multi_err"}, 32'(multi_sel_err), 32'(merr_m));
    check_eq({tag, ".latch_cnt"}, 32'(latch_cnt), 32'(lcnt_m));
    check_eq({tag, ".pulse_idle"}, 32'(latch_pulse), 32'd0);
  endtask

  task automatic latch_and_check(input string tag);
    int p0;
    p0 = pulse_cnt;
    do_latch();
    check_eq({tag, ".pulses"}, 32'(pulse_cnt - p0), 32'd1);
    check_all(tag);
  endtask

  initial begin
    int p0;
    int n;
    logic [7:0] v;
    en_m = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    check_all("reset");
    #1 rst = 1'b1;

    // Basic frame 1,0,0,1.
    set_enable(1'b1);
    send_frame(8'b1001, 4);
    latch_and_check("frame1001");

    // Enable falls: columns follow the synchronized enable two edges later.
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("en_fall_hold", 32'(columns), 32'b001);
    @(negedge clk);
    check_eq("en_fall_drop", 32'(columns), 32'b000);
    en_m = 1'b0;
    send_frame(8'b1001, 4);
    latch_and_check("gated");
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 en_m = 1'b1;
    check_all("en_rise");

    // Frame length errors.
    send_frame(8'b101, 3);
    latch_and_check("short3");
    send_frame(8'b10100, 5);
    latch_and_check("long5");
    send_frame(8'b0001, 4);
    latch_and_check("exact4");

    // Multi-select detection.
    send_frame(8'b0110, 4);
    latch_and_check("multi0110");
    send_frame(8'b0010, 4);
    latch_and_check("single0010");

    // Coincident ser_clk and stcp rises.
    send_frame(8'b1010, 4);
    p0 = pulse_cnt;
    do_both(1'b1);
    check_eq("both.pulses", 32'(pulse_cnt - p0), 32'd1);
    check_all("both");
    send_frame(8'b011, 3);
    latch_and_check("after_both");

    // Reset mid-frame.
    send_frame(8'b0100, 4);
    latch_and_check("pre_reset");
    send_frame(8'b11, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst.columns", 32'(columns), 32'd0);
    check_eq("rst.extra", 32'(extra_bit_out), 32'd0);
    check_eq("rst.latch_cnt", 32'(latch_cnt), 32'd0);
    check_eq("rst.count_err", 32'(count_err), 32'd0);
    check_eq("rst.multi_err", 32'(multi_sel_err), 32'd0);
    check_eq("rst.pulse", 32'(latch_pulse), 32'd0);
    wait_clk(2);
    rst = 1'b1;
    send_frame(8'b1100, 4);
    latch_and_check("post_reset");

    // Random frames.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) set_enable(1'($urandom_range(0, 1)));
      n = $urandom_range(0, 6);
      v = 8'($urandom);
      send_frame(v, n);
      if ($urandom_range(0, 3) == 0) check_all("rnd_noshiftlatch");
      if ($urandom_range(0, 4) == 0) begin
        do_both(1'($urandom_range(0, 1)));
        check_all("rnd_both");
      end else begin
        latch_and_check("rnd");
      end
    end

    wait_clk(4);
    check_eq("pulse_total", 32'(pulse_cnt), 32'(total_lat));
    check_eq("pulse_width", 32'(wide_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/column_select_rx.md
Name: column_select_rx

Overview:
- Receive-side model and monitor for the column-select serial chain: ser / ser_clk / stcp / enable.
- Behaves as a synchronous, oversampled equivalent of a 595-style shift and storage register chain.
- Latches column-select words and flags protocol errors.
- Used as a loopback checker in FPGA builds and as the bench responder for the column-select transmitter.

Parameters:
- COLUMN_NUMBER, 3: number of column-select outputs. Chain length CHAIN = COLUMN_NUMBER + 1 (columns plus extra bit).
- SYNC_STAGES, 2: synchronizer depth applied to all four serial inputs. Legal range 2..4.
- CNT_W, 16: width of the latch counter.

Ports:
- clk  input  1  system clock; every serial input is sampled on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- ser  input  1  serial data.
- ser_clk  input  1  shift clock; a rising edge shifts in one bit.
- stcp  input  1  storage clock; a rising edge latches the shift register.
- enable  input  1  output enable from the transmitter, active-high.
- columns  output  COLUMN_NUMBER  latched column bits gated by synchronized enable.
- extra_bit_out  output  1  latched extra bit; not gated by enable.
- latch_pulse  output  1  one-cycle strobe on each accepted stcp edge.
- count_err  output  1  last latched frame did not contain exactly CHAIN shifts.
- multi_sel_err  output  1  last latched column word has more than one bit set.
- latch_cnt  output  CNT_W  number of latches since reset; wraps to 0.

Behaviour:
- Reset (rst=0, asynchronous): all outputs, all synchronizer flops, shift_reg, storage_reg, bit counter and previous-value edge flops clear to 0. Release is synchronous to clk through the same flops.
- Synchronization:
  - ser, ser_clk, stcp and enable each pass through SYNC_STAGES flops.
  - Edge detection compares the last stage with a one-cycle-delayed copy.
  - The transmitter must hold ser stable at least SYNC_STAGES+1 clk cycles around each ser_clk rise. ser_clk high and low phases must each be at least 2 clk cycles.
- Shift:
  - On a detected ser_clk rise: shift_reg <= {shift_reg[CHAIN-2:0], ser_sync}. ser_sync is the synchronized ser taken in that same cycle.
  - The first bit sent ends in shift_reg[CHAIN-1], which is the extra bit.
  - Bit mapping: shift_reg[CHAIN-1] = extra bit, shift_reg[COLUMN_NUMBER-1:0] = columns.
  - bit_cnt increments per shift and saturates at 2*CHAIN.
- Latch:
  - On a detected stcp rise: storage_reg <= shift_reg, the value before any shift in that cycle.
  - latch_pulse=1 for exactly one cycle, 1 cycle after edge detection.
  - latch_cnt increments, wrapping at 2^CNT_W.
  - count_err <= (bit_cnt != CHAIN).
  - multi_sel_err <= (popcount(shift_reg column field) > 1).
  - bit_cnt clears to 0.
- Simultaneous ser_clk and stcp rises in one cycle:
  - The shift happens and storage takes the pre-shift contents.
  - The bit shifted in that cycle counts toward the next frame, so bit_cnt becomes 1.
- Outputs:
  - columns = storage_reg column field AND enable_sync, combinational from registers. columns drop to 0 in the same cycle enable_sync falls.
  - extra_bit_out = storage_reg[CHAIN-1].
  - Error flags hold until the next latch.
- Shifting without latching leaves storage and outputs unchanged.
- stcp with zero preceding shifts latches unchanged shift_reg and sets count_err.
- Latency, from a ser_clk or stcp input edge to its effect: SYNC_STAGES+1 clk cycles.
- Reset mid-frame discards partial bits. The next frame counts from 0.

Test Plan:
- Reset release, then shift 4 bits (1,0,0,1), then stcp with enable=1 -> extra_bit_out=1, columns=3'b001, latch_pulse one cycle, count_err=0, multi_sel_err=0, latch_cnt=1.
- Same frame with enable held 0 -> columns=3'b000, extra_bit_out=1. Then raise enable -> columns=3'b001 within SYNC_STAGES+1 cycles.
- Shift 3 bits, then stcp -> count_err=1. Shift 5 bits, then stcp -> count_err=1. Then an exact 4-bit frame -> count_err clears.
- Frame 0,1,1,0 -> columns=3'b110, multi_sel_err=1. Next frame 0,0,1,0 -> multi_sel_err=0, columns=3'b010.
- ser_clk and stcp rising in the same cycle after a 4-bit frame -> storage holds the pre-shift word, and the following frame needs 3 more shifts for count_err=0.
- rst asserted after 2 shifts with storage=3'b100 -> all outputs 0 immediately. After release, a full frame latches correctly and latch_cnt=1.
